// File: rtl/debug_pkg.sv
// Shared types and constants for the debug serial transmitter.
// The optional checksum byte is enabled by DEBUG_TX_CHECKSUM_EN in debug_uart_tx.
package debug_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        FINISH
    } frame_state_e;

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } bit_state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         PORT_COUNT        = 7;

    // Bit counter positions: 0 = start, 1..8 = data LSB first, 9 = stop.
    localparam logic [3:0] LAST_DATA_BIT_IDX = 4'd8;
    localparam logic [3:0] STOP_BIT_IDX      = 4'd9;

    function automatic logic [7:0] sum_bytes(input logic [PORT_COUNT-1:0][7:0] bytes);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < PORT_COUNT; i++) begin
            acc = acc + bytes[i];
        end
        return acc;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 bit engine: shifts one byte out LSB first, CLKS_PER_BIT cycles per bit.
// A reload presented in the final stop-bit cycle starts the next byte with no idle gap.
module uart_tx_byte
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    bit_state_e       state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end = (cyc_q == CNT_LAST);
    assign tx      = tx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= B_IDLE;
            cyc_q   <= '0;
            bit_q   <= 4'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        byte_done = 1'b0;

        if (state_q != B_IDLE) begin
            cyc_d = bit_end ? '0 : cyc_q + 1'b1;
        end

        case (state_q)
            B_IDLE: begin
                tx_d = 1'b1;
                if (load) begin
                    state_d = B_START;
                    tx_d    = 1'b0;
                    shift_d = data;
                    bit_d   = 4'd0;
                    cyc_d   = '0;
                end
            end
            B_START: begin
                if (bit_end) begin
                    state_d = B_DATA;
                    bit_d   = 4'd1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
            B_DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_DATA_BIT_IDX) begin
                        state_d = B_STOP;
                        bit_d   = STOP_BIT_IDX;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            B_STOP: begin
                if (bit_end) begin
                    // The stop bit's last cycle doubles as the idle slot for a reload.
                    byte_done = 1'b1;
                    bit_d     = 4'd0;
                    if (load) begin
                        state_d = B_START;
                        tx_d    = 1'b0;
                        shift_d = data;
                    end else begin
                        state_d = B_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = B_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/debug_uart_tx.sv
// Snapshots the seven CPU debug ports and sends SYNC, port1..port7 as UART 8N1 bytes.
// Define DEBUG_TX_CHECKSUM_EN to append a ninth byte: the 8-bit sum of the seven ports.
module debug_uart_tx
    import debug_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] debug_port1,
    input  logic [7:0] debug_port2,
    input  logic [7:0] debug_port3,
    input  logic [7:0] debug_port4,
    input  logic [7:0] debug_port5,
    input  logic [7:0] debug_port6,
    input  logic [7:0] debug_port7,
    output logic       tx,
    output logic       busy,
    output logic       done
);

`ifdef DEBUG_TX_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd7;
`endif

    frame_state_e                state_q, state_d;
    logic [3:0]                  idx_q, idx_d;
    logic [PORT_COUNT-1:0][7:0]  snap_q, snap_d;
    logic                        accept;
    logic                        eng_load;
    logic                        byte_done;
    logic [3:0]                  sel_idx;
    logic [7:0]                  load_byte;

`ifdef DEBUG_TX_CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum = sum_bytes(snap_q);
`endif

    // FINISH already reports busy low, so a start there is taken without a gap.
    assign accept = start && ((state_q == IDLE) || (state_q == FINISH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        snap_d = snap_q;
        if (accept) begin
            snap_d = {debug_port7, debug_port6, debug_port5, debug_port4,
                      debug_port3, debug_port2, debug_port1};
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        eng_load = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                idx_d    = 4'd0;
                eng_load = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                busy = 1'b1;
                if (byte_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        eng_load = 1'b1;
                    end
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = accept ? LOAD : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The engine reloads in the same cycle the index advances, so select the upcoming byte.
    always_comb begin
        sel_idx   = (state_q == LOAD) ? 4'd0 : idx_q + 4'd1;
        load_byte = SYNC_BYTE;
        if ((sel_idx >= 4'd1) && (sel_idx <= 4'd7)) begin
            load_byte = snap_q[sel_idx[2:0] - 3'd1];
        end
`ifdef DEBUG_TX_CHECKSUM_EN
        else if (sel_idx == 4'd8) begin
            load_byte = checksum;
        end
`endif
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk      (clk),
        .reset    (reset),
        .load     (eng_load),
        .data     (load_byte),
        .tx       (tx),
        .byte_done(byte_done)
    );

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx with CLKS_PER_BIT=4; expected bytes and packet
// lengths are queued at stimulus time and checked by independent tx/done monitors.
module tb_debug_uart_tx;

    localparam int CPB = 4;
`ifdef DEBUG_TX_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
    localparam int NBYTES  = 9;
`else
    localparam bit CSUM_EN = 1'b0;
    localparam int NBYTES  = 8;
`endif
    localparam int PKT_CYCLES = NBYTES * 10 * CPB + 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] p1, p2, p3, p4, p5, p6, p7;
    logic       tx, busy, done;

    logic [7:0] exp_q[$];
    int         exp_len_q[$];
    int         checks = 0;
    int         errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    debug_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .debug_port1(p1),
        .debug_port2(p2),
        .debug_port3(p3),
        .debug_port4(p4),
        .debug_port5(p5),
        .debug_port6(p6),
        .debug_port7(p7),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ports(input logic [7:0] a, b, c, d, e, f, g);
        p1 = a; p2 = b; p3 = c; p4 = d; p5 = e; p6 = f; p7 = g;
    endtask

    task automatic push_packet(input logic [7:0] a, b, c, d, e, f, g, input logic [7:0] csum);
        exp_q.push_back(8'hA5);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
        exp_q.push_back(d); exp_q.push_back(e); exp_q.push_back(f);
        exp_q.push_back(g);
        if (CSUM_EN) exp_q.push_back(csum);
        exp_len_q.push_back(PKT_CYCLES);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    // ---------------- tx byte monitor ----------------
    logic [9:0] mon_bits;
    bit         mon_ok;
    bit         mon_abort;

    always begin
        @(negedge clk);
        if (reset === 1'b0 && tx === 1'b0) begin
            mon_ok    = 1'b1;
            mon_abort = 1'b0;
            for (int b = 0; b < 10 && !mon_abort; b++) begin
                for (int c = 0; c < CPB && !mon_abort; c++) begin
                    if (!(b == 0 && c == 0)) @(negedge clk);
                    if (reset !== 1'b0) mon_abort = 1'b1;
                    else if (c == 0) mon_bits[b] = tx;
                    else if (tx !== mon_bits[b]) mon_ok = 1'b0;
                end
            end
            if (!mon_abort) begin
                check("frame_shape", {31'd0, mon_ok && mon_bits[0] == 1'b0 && mon_bits[9] == 1'b1}, 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", mon_bits[8:1], $time);
                end else begin
                    check("byte", {24'd0, mon_bits[8:1]}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // ---------------- busy/done monitor ----------------
    int pkt_cnt = 0;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            pkt_cnt = 0;
        end else if (done === 1'b1) begin
            check("done_busy_low", {31'd0, busy}, 32'd0);
            if (exp_len_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done expected none at %0t", $time);
            end else begin
                check("packet_cycles", pkt_cnt + 1, exp_len_q.pop_front());
            end
            pkt_cnt = 0;
        end else if (busy === 1'b1) begin
            pkt_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_ports(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Ports 01..07: accept latency and basic framing.
        set_ports(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
        push_packet(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h1C);
        pulse_start();
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("load_tx_high", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("first_start_bit", {31'd0, tx}, 32'd0);
        wait_done("done_incrementing");
        repeat (4) @(negedge clk);

        // All ones: checksum wraps 0x6F9 -> 0xF9.
        set_ports(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        push_packet(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9);
        pulse_start();
        wait_done("done_all_ones");
        repeat (4) @(negedge clk);

        // Ports change and start re-pulses mid-packet: both must be ignored.
        set_ports(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70);
        push_packet(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'hC0);
        pulse_start();
        repeat (48) @(negedge clk);
        set_ports(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)));
        pulse_start();
        wait_done("done_ignored_start");
        repeat (5) @(negedge clk);
        check("idle_after_ignored_start", {31'd0, busy}, 32'd0);

        // Reset in the middle of the third byte, held for three edges.
        set_ports(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77);
        push_packet(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'hDC);
        pulse_start();
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        exp_len_q.delete();
        check("midreset_tx", {31'd0, tx}, 32'd1);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("release_tx", {31'd0, tx}, 32'd1);
        check("release_busy", {31'd0, busy}, 32'd0);
        check("release_done", {31'd0, done}, 32'd0);
        repeat (5) @(negedge clk);
        set_ports(8'h3C, 8'h00, 8'h81, 8'h7E, 8'h55, 8'hAA, 8'h01);
        push_packet(8'h3C, 8'h00, 8'h81, 8'h7E, 8'h55, 8'hAA, 8'h01, 8'h3B);
        pulse_start();
        wait_done("done_after_reset");
        repeat (4) @(negedge clk);

        // start held high: second packet follows the done cycle after one LOAD cycle.
        set_ports(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE);
        push_packet(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'h48);
        push_packet(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'h48);
        start = 1'b1;
        wait_done("done_held_first");
        @(negedge clk);
        start = 1'b0;
        check("b2b_load_tx", {31'd0, tx}, 32'd1);
        check("b2b_load_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("b2b_start_bit", {31'd0, tx}, 32'd0);
        wait_done("done_held_second");

        repeat (20) @(negedge clk);
        check("bytes_drained", exp_q.size(), 32'd0);
        check("packets_drained", exp_len_q.size(), 32'd0);
        check("final_idle_tx", {31'd0, tx}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
